display_scan_mux: RTL and testbench

- Time-multiplexed refresh controller for the 8-digit common-anode 7-segment display.
- Holds eight BCD digits in a shadow register and scans them one slot at a time.
- Presents one 4-bit BCD nibble per slot to the downstream BCD-to-7-segment decoder, together with the matching active-low one-hot anode vector.
- Adds leading-zero blanking, per-digit enables, an anti-ghosting dark interval and an invalid-BCD flag.

---
 rtl/display_scan_mux.sv | 100 ++++++++++
 tb/tb_display_scan_mux.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_mux.sv
// Refresh controller for an 8-digit common-anode 7-segment display.
// It scans a shadow copy of eight BCD digits one slot at a time.
// Each slot starts with a short dark interval to stop ghosting.
// Digits are suppressed when disabled, when the nibble is not valid BCD,
// or when they are leading zeros. All outputs are registered.
module display_scan_mux #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLANK_CYC   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_in,
  input  logic        load,
  input  logic [7:0]  digit_en,
  input  logic        blank_lz,
  output logic [7:0]  an,
  output logic [3:0]  bcd_out,
  output logic [2:0]  sel,
  output logic        tick,
  output logic        bcd_err
);

  localparam int unsigned CntW = $clog2(REFRESH_DIV);
  localparam logic [CntW-1:0] CntMax   = CntW'(REFRESH_DIV - 1);
  localparam logic [CntW-1:0] BlankEnd = CntW'(BLANK_CYC);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      sel_q, sel_d;
  logic [31:0]     shadow_q, shadow_d;
  logic [7:0]      an_q, an_d;
  logic [3:0]      bcd_q, bcd_d;
  logic            tick_q, tick_d;
  logic            err_q, err_d;

  logic            slot_end;
  logic [7:0]      lz;
  logic            upper_zero;
  logic            suppress;

  // Prescaler, slot index and shadow register next state.
  always_comb begin
    slot_end = (cnt_q == CntMax);
    cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
    sel_d    = slot_end ? sel_q + 3'd1 : sel_q;
    shadow_d = load ? data_in : shadow_q;
    tick_d   = (cnt_d == CntMax);
  end

  // lz[i] is set when nibbles 7..i of the next shadow value are all zero.
  always_comb begin
    lz         = '0;
    upper_zero = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      upper_zero = upper_zero & (shadow_d[4*i +: 4] == 4'd0);
      lz[i]      = upper_zero;
    end
  end

  // Output next state. It is built from next-state values so that a load or a
  // slot advance shows up on the same edge that applies it.
  always_comb begin
    bcd_d    = shadow_d[{sel_d, 2'b00} +: 4];
    err_d    = (bcd_d > 4'd9);
    // Digit 0 is never treated as a leading zero, so a value of 0 still shows "0".
    suppress = ~digit_en[sel_d] | err_d | (blank_lz & (sel_d != 3'd0) & lz[sel_d]);
    if ((cnt_d < BlankEnd) || suppress) begin
      an_d = 8'hFF;
    end else begin
      an_d = ~(8'h01 << sel_d);
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      sel_q    <= 3'd7;
      shadow_q <= '0;
      an_q     <= 8'hFF;
      bcd_q    <= 4'd0;
      tick_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      an_q     <= an_d;
      bcd_q    <= bcd_d;
      tick_q   <= tick_d;
      err_q    <= err_d;
    end
  end

  assign an      = an_q;
  assign bcd_out = bcd_q;
  assign sel     = sel_q;
  assign tick    = tick_q;
  assign bcd_err = err_q;

endmodule

// File: tb/tb_display_scan_mux.sv
// Directed bench for display_scan_mux with REFRESH_DIV = 8 and BLANK_CYC = 2.
// Full frames are checked against hand-computed lit/err masks per data pattern,
// and a few short sequences cover the load-on-tick, enable-change and reset cases.
module tb_display_scan_mux;

  localparam int unsigned Div   = 8;
  localparam int unsigned Blank = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] data_in;
  logic        load;
  logic [7:0]  digit_en;
  logic        blank_lz;
  logic [7:0]  an;
  logic [3:0]  bcd_out;
  logic [2:0]  sel;
  logic        tick;
  logic        bcd_err;

  display_scan_mux #(
    .REFRESH_DIV(Div),
    .BLANK_CYC  (Blank)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .data_in (data_in),
    .load    (load),
    .digit_en(digit_en),
    .blank_lz(blank_lz),
    .an      (an),
    .bcd_out (bcd_out),
    .sel     (sel),
    .tick    (tick),
    .bcd_err (bcd_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  en;
    logic        blz;
    logic [7:0]  lit;  // slots whose anode turns on after the dark interval
    logic [7:0]  err;  // slots where bcd_err is expected high
  } vec_t;

  vec_t vecs[6];

  int n_chk  = 0;
  int n_fail = 0;

  // Timing reference: offset within slot and slot index, advanced per clock.
  int unsigned exp_cnt = 0;
  int unsigned exp_sel = 7;

  logic [31:0] cur_data;
  logic [7:0]  cur_lit;
  logic [7:0]  cur_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (slot %0d offset %0d, t=%0t)",
               name, act, exp, exp_sel, exp_cnt, $time);
    end
  endtask

  // One clock; sampling point is 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (reset) begin
      exp_cnt = 0;
      exp_sel = 7;
    end else if (exp_cnt == Div - 1) begin
      exp_cnt = 0;
      exp_sel = (exp_sel + 1) % 8;
    end else begin
      exp_cnt++;
    end
  endtask

  task automatic check_cycle();
    logic [7:0] exp_an;
    logic [3:0] exp_bcd;
    exp_an  = (exp_cnt < Blank || !cur_lit[exp_sel]) ? 8'hFF : ~(8'h01 << exp_sel);
    exp_bcd = cur_data[exp_sel*4 +: 4];
    chk("an", {24'd0, an}, {24'd0, exp_an});
    chk("bcd_out", {28'd0, bcd_out}, {28'd0, exp_bcd});
    chk("sel", {29'd0, sel}, exp_sel);
    chk("tick", {31'd0, tick}, {31'd0, (exp_cnt == Div - 1)});
    chk("bcd_err", {31'd0, bcd_err}, {31'd0, cur_err[exp_sel]});
  endtask

  task automatic wait_offset(input int unsigned off);
    for (int k = 0; k < 2 * Div && exp_cnt != off; k++) step();
  endtask

  initial begin
    int n;

    vecs[0] = '{data: 32'h87654321, en: 8'hFF, blz: 1'b0, lit: 8'hFF,        err: 8'h00};
    vecs[1] = '{data: 32'h00000305, en: 8'hFF, blz: 1'b1, lit: 8'b0000_0111, err: 8'h00};
    vecs[2] = '{data: 32'h00000000, en: 8'hFF, blz: 1'b1, lit: 8'b0000_0001, err: 8'h00};
    vecs[3] = '{data: 32'h0000A012, en: 8'hFF, blz: 1'b0, lit: 8'b1111_0111, err: 8'h08};
    vecs[4] = '{data: 32'h87654321, en: 8'hF7, blz: 1'b0, lit: 8'b1111_0111, err: 8'h00};
    vecs[5] = '{data: 32'h0000A012, en: 8'hFF, blz: 1'b1, lit: 8'b0000_0111, err: 8'h08};

    reset    = 1'b1;
    data_in  = 32'hFFFF_FFFF;
    load     = 1'b0;
    digit_en = 8'hFF;
    blank_lz = 1'b0;
    step();
    step();
    chk("reset an", {24'd0, an}, 32'hFF);
    chk("reset bcd_out", {28'd0, bcd_out}, 32'h0);
    chk("reset sel", {29'd0, sel}, 32'd7);
    chk("reset tick", {31'd0, tick}, 32'd0);
    chk("reset bcd_err", {31'd0, bcd_err}, 32'd0);
    reset = 1'b0;

    // Full-frame checks for each data pattern.
    for (int v = 0; v < 6; v++) begin
      data_in  = vecs[v].data;
      digit_en = vecs[v].en;
      blank_lz = vecs[v].blz;
      load     = 1'b1;
      step();
      load     = 1'b0;
      data_in  = 32'hDEAD_BEEF;
      cur_data = vecs[v].data;
      cur_lit  = vecs[v].lit;
      cur_err  = vecs[v].err;
      wait_offset(Div - 1);
      step();
      for (int k = 0; k < 8 * Div; k++) begin
        check_cycle();
        step();
      end
    end

    // Load on the tick cycle: the new slot shows new data from its first cycle.
    wait_offset(Div - 1);
    chk("tick before load", {31'd0, tick}, 32'd1);
    data_in  = 32'h13572468;
    digit_en = 8'hFF;
    blank_lz = 1'b0;
    load     = 1'b1;
    step();
    load     = 1'b0;
    data_in  = 32'h0;
    cur_data = 32'h13572468;
    cur_lit  = 8'hFF;
    cur_err  = 8'h00;
    for (int k = 0; k < Div; k++) begin
      check_cycle();
      step();
    end

    // Disabling the current digit mid-slot darkens it on the next edge.
    wait_offset(3);
    chk("lit before disable", {24'd0, an}, {24'd0, ~(8'h01 << exp_sel)});
    digit_en = ~(8'h01 << exp_sel);
    cur_lit  = digit_en;
    step();
    check_cycle();
    digit_en = 8'hFF;
    cur_lit  = 8'hFF;
    step();
    check_cycle();

    // Reset at offset 5 of slot 4.
    for (int k = 0; k < 10 * Div && !(exp_sel == 4 && exp_cnt == 5); k++) step();
    chk("reached slot 4", exp_sel, 32'd4);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid reset an", {24'd0, an}, 32'hFF);
    chk("mid reset sel", {29'd0, sel}, 32'd7);
    chk("mid reset bcd_out", {28'd0, bcd_out}, 32'h0);
    chk("mid reset tick", {31'd0, tick}, 32'd0);
    n = 0;
    while (tick !== 1'b1 && n < 3 * Div) begin
      step();
      n++;
    end
    chk("cycles to first tick", n, Div - 1);
    step();
    chk("first slot sel", {29'd0, sel}, 32'd0);
    chk("first slot bcd_out", {28'd0, bcd_out}, 32'h0);
    chk("first slot an", {24'd0, an}, 32'hFF);
    chk("first slot tick", {31'd0, tick}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
